// File: rtl/mont_pkg.sv
// Shared definitions for the parametrised Montgomery exponentiator.
// Contents:
//   - state_t: controller state encoding.
//   - MM_LAT(k): multiplier latency, in cycles from mm_start to mm_done.
//   - Cycle-count helpers for the whole exponentiation, measured from the
//     cycle in which start is accepted to the cycle in which done is high.
package mont_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TOMONT,
        ST_SQR,
        ST_MUL,
        ST_FROMMONT,
        ST_DONE
    } state_t;

    // Extra cycle per multiply state, beyond the multiplier latency itself.
    localparam int MM_STATE_EXTRA = 1;
    // Cycles outside the multiply states: accept cycle, LOAD and DONE.
    localparam int EXPO_FIXED     = 3;

    function automatic int MM_LAT(input int k);
        return k + 2;
    endfunction

    function automatic int expo_cycles(input int k, input int exp_w, input int pop);
        return EXPO_FIXED + (exp_w + 2 + pop) * (MM_LAT(k) + MM_STATE_EXTRA);
    endfunction

    function automatic int expo_cycles_ct(input int k, input int exp_w);
        return EXPO_FIXED + (2 * exp_w + 2) * (MM_LAT(k) + MM_STATE_EXTRA);
    endfunction

endpackage

// File: rtl/mont_mul_core.sv
// Radix-2 interleaved Montgomery multiplier: p = a*b*2^-K mod m, fully reduced.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (control state only)
//   start        - one-cycle pulse; a, b, m are captured on this cycle
//   a, b, m      - operands (a, b < m, m odd)
//   p            - result, valid while done is high
//   done         - one-cycle pulse, K+2 cycles after start
module mont_mul_core
    import mont_pkg::*;
#(
    parameter int K = 192
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic [K-1:0] m,
    output logic [K-1:0] p,
    output logic         done
);

    localparam int CW = $clog2(K + 1);

    logic [K-1:0]  a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d;
    logic [K:0]    t_q, t_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, fin_q, fin_d, done_q, done_d;
    logic [K+1:0]  sum_ab, sum_m;
    logic [K:0]    t_minus_m;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        m_d    = m_q;
        p_d    = p_q;
        t_d    = t_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        fin_d  = fin_q;
        done_d = 1'b0;

        // t stays below 2m, so t + b + m < 4m fits in K+2 bits before the halving.
        sum_ab    = {1'b0, t_q} + (a_q[0] ? {2'b00, b_q} : '0);
        sum_m     = sum_ab[0] ? sum_ab + {2'b00, m_q} : sum_ab;
        t_minus_m = t_q - {1'b0, m_q};

        if (start) begin
            a_d   = a;
            b_d   = b;
            m_d   = m;
            t_d   = '0;
            cnt_d = '0;
            run_d = 1'b1;
            fin_d = 1'b0;
        end else if (run_q) begin
            t_d   = sum_m[K+1:1];
            a_d   = a_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(K - 1)) begin
                run_d = 1'b0;
                fin_d = 1'b1;
            end
        end else if (fin_q) begin
            // Single conditional subtract brings t < 2m into [0, m).
            p_d    = (t_q >= {1'b0, m_q}) ? t_minus_m[K-1:0] : t_q[K-1:0];
            fin_d  = 1'b0;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            fin_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            fin_q  <= fin_d;
            done_q <= done_d;
        end
        a_q   <= a_d;
        b_q   <= b_d;
        m_q   <= m_d;
        t_q   <= t_d;
        cnt_q <= cnt_d;
        p_q   <= p_d;
    end

    assign p    = p_q;
    assign done = done_q;

endmodule

// File: rtl/mont_expo_param.sv
// Modular exponentiation z = x^y mod m, left-to-right square-and-multiply in
// the Montgomery domain, driving one mont_mul_core.
// Build option: MONT_EXPO_CT_EN - when defined, a multiply is issued for every
// exponent bit and discarded for zero bits, giving data-independent latency.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - request, honoured only when idle
//   x, y, m           - base (< m), exponent, modulus (odd)
//   r_mod_m, r2_mod_m - 2^K mod m and 2^2K mod m
//   z                 - result, held until the next accepted start
//   busy              - operation in progress
//   done              - one-cycle pulse when z is updated
//   err               - set with done when m is even (z forced to 0)
module mont_expo_param
    import mont_pkg::*;
#(
    parameter int K     = 192,
    parameter int EXP_W = K,
    parameter int LOGE  = $clog2(EXP_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [K-1:0]     x,
    input  logic [EXP_W-1:0] y,
    input  logic [K-1:0]     m,
    input  logic [K-1:0]     r_mod_m,
    input  logic [K-1:0]     r2_mod_m,
    output logic [K-1:0]     z,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef MONT_EXPO_CT_EN
    localparam bit CT_EN = 1'b1;
`else
    localparam bit CT_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [K-1:0]     x_q, x_d, m_q, m_d, rmod_q, rmod_d, r2mod_q, r2mod_d;
    logic [K-1:0]     acc_q, acc_d, xm_q, xm_d, zint_q, zint_d, z_q, z_d;
    logic [EXP_W-1:0] y_q, y_d, y_sh;
    logic [LOGE-1:0]  i_q, i_d;
    logic             mm_wait_q, mm_wait_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             ybit, last_bit, mm_start, mm_done;
    logic [K-1:0]     mm_a, mm_b, mm_p;

    assign y_sh     = y_q >> i_q;
    assign ybit     = y_sh[0];
    assign last_bit = (i_q == '0);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        m_d       = m_q;
        rmod_d    = rmod_q;
        r2mod_d   = r2mod_q;
        acc_d     = acc_q;
        xm_d      = xm_q;
        zint_d    = zint_q;
        z_d       = z_q;
        i_d       = i_q;
        mm_wait_d = mm_wait_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mm_start  = 1'b0;
        mm_a      = acc_q;
        mm_b      = acc_q;

        // Every multiply state launches once on entry, then waits for mm_done.
        if (state_q inside {ST_TOMONT, ST_SQR, ST_MUL, ST_FROMMONT}) begin
            if (!mm_wait_q) begin
                mm_start  = 1'b1;
                mm_wait_d = 1'b1;
            end else if (mm_done) begin
                mm_wait_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    m_d     = m;
                    rmod_d  = r_mod_m;
                    r2mod_d = r2_mod_m;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!m_q[0]) begin
                    state_d = ST_DONE;
                end else begin
                    acc_d   = rmod_q;
                    i_d     = LOGE'(EXP_W - 1);
                    state_d = ST_TOMONT;
                end
            end
            ST_TOMONT: begin
                mm_a = x_q;
                mm_b = r2mod_q;
                if (mm_wait_q && mm_done) begin
                    xm_d    = mm_p;
                    state_d = ST_SQR;
                end
            end
            // The bit-advance step is resolved in the capture cycle of SQR/MUL,
            // so it costs no cycle of its own.
            ST_SQR: begin
                if (mm_wait_q && mm_done) begin
                    acc_d = mm_p;
                    if (CT_EN || ybit) begin
                        state_d = ST_MUL;
                    end else if (last_bit) begin
                        state_d = ST_FROMMONT;
                    end else begin
                        i_d     = i_q - LOGE'(1);
                        state_d = ST_SQR;
                    end
                end
            end
            ST_MUL: begin
                mm_b = xm_q;
                if (mm_wait_q && mm_done) begin
                    // In constant-time mode the product for a zero bit is dropped.
                    if (!CT_EN || ybit) begin
                        acc_d = mm_p;
                    end
                    if (last_bit) begin
                        state_d = ST_FROMMONT;
                    end else begin
                        i_d     = i_q - LOGE'(1);
                        state_d = ST_SQR;
                    end
                end
            end
            ST_FROMMONT: begin
                mm_b = {{(K-1){1'b0}}, 1'b1};
                if (mm_wait_q && mm_done) begin
                    zint_d  = mm_p;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                z_d     = m_q[0] ? zint_q : '0;
                err_d   = ~m_q[0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mm_wait_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            z_q       <= '0;
        end else begin
            state_q   <= state_d;
            mm_wait_q <= mm_wait_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            z_q       <= z_d;
        end
        x_q     <= x_d;
        y_q     <= y_d;
        m_q     <= m_d;
        rmod_q  <= rmod_d;
        r2mod_q <= r2mod_d;
        acc_q   <= acc_d;
        xm_q    <= xm_d;
        zint_q  <= zint_d;
        i_q     <= i_d;
    end

    mont_mul_core #(.K(K)) u_mm (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .m     (m_q),
        .p     (mm_p),
        .done  (mm_done)
    );

    assign z    = z_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: doc/mont_expo_param.md
Name: mont_expo_param

Overview:
- Parametrised modular exponentiation engine. Computes z = x^y mod m with left-to-right binary square-and-multiply in the Montgomery domain.
- Successor to the fixed-modulus P-192 exponentiator:
  - operand width, exponent width and modulus are generic;
  - modulus and Montgomery constants are runtime inputs;
  - adds a busy/done handshake and an odd-modulus error check.
- Sits beside the SHA datapath as the public-key arithmetic unit; drives one Montgomery multiplier sub-module.

Parameters:
- K, 192, operand/modulus width in bits (≥ 8).
- EXP_W, K, exponent width in bits (1..K).
- LOGE, $clog2(EXP_W+1), bit-counter width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x  in  K  base; caller guarantees x < m.
- y  in  EXP_W  exponent.
- m  in  K  modulus; must be odd, top bit may be 0.
- r_mod_m  in  K  R mod m, with R = 2^K (Montgomery one).
- r2_mod_m  in  K  R^2 mod m.
- z  out  K  result, valid when done=1; held until next accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when z is updated.
- err  out  1  set with done if m[0]=0; z=0 in that case.

Behaviour:
- Reset: busy=0, done=0, err=0, z=0, FSM→IDLE. Reset mid-operation aborts immediately; any in-flight multiply is discarded, with no done pulse.
- start in IDLE:
  - latches x, y, m, r_mod_m and r2_mod_m into internal registers;
  - ports may change afterwards;
  - start while busy is ignored.
- States:
  - IDLE: wait start → LOAD.
  - LOAD: if m[0]=0 → DONE with err=1. Else acc←r_mod_m, bit index i←EXP_W-1 → TOMONT.
  - TOMONT: xm←MM(x, r2_mod_m) → SQR.
  - SQR: acc←MM(acc, acc). Then if y[i]=1 → MUL, else → NEXT.
  - MUL: acc←MM(acc, xm) → NEXT.
  - NEXT: if i=0 → FROMMONT, else i←i-1 → SQR.
  - FROMMONT: z_int←MM(acc, 1) → DONE.
  - DONE: z←z_int, done=1 for one cycle, busy=0 → IDLE.
- Each MM state:
  - pulses mm_start one cycle;
  - waits for mm_done;
  - captures the result on the mm_done cycle.
- MM(a,b) = a·b·R⁻¹ mod m, fully reduced (< m).
- Latency: multiplier = K+2 cycles from mm_start to mm_done. Total = 3 + (EXP_W + 2 + popcount(y))·(K+3) cycles, ±1 for DONE, start-accept to done.
- y=0 gives z=1 (m>1). m=1 gives z=0.
- Result is bit-exact and independent of leading zeros in y.

Optional Feature:
- MONT_EXPO_CT_EN
  - Defined: constant-time mode. MUL is executed for every bit; when y[i]=0 the product is computed but discarded (acc unchanged). Latency fixed at 3 + (2·EXP_W + 2)·(K+3).
  - Undefined: MUL is skipped for zero bits, as in the State list.

Decomposition:
- Package mont_pkg:
  - state enum typedef;
  - MM_LAT(K) latency function;
  - localparam for the CT/non-CT cycle formulas, used by the bench.
- Sub-module mont_mul_core:
  - radix-2 interleaved Montgomery multiplier parametrised by K;
  - ports clk, reset, start, a, b, m, p, done;
  - K+1-bit internal accumulator, final conditional subtract.

Test Plan:
- K=16, m=0xFFF1, r_mod_m=0x000F, r2_mod_m=0x00E1, x=2, y=10 → z=0x0400, err=0; done after the formula cycle count.
- Same m, x=3, y=0xFFF0 (Fermat, EXP_W=16) → z=0x0001. Same m, x=0x1234, y=0 → z=0x0001.
- K=192, m=2^192-2^64-1, x=2, y=192 → z=2^64+1 (0x…010000000000000001).
- m=0xFFF0 (even) → done after LOAD+DONE, err=1, z=0. start asserted during busy → ignored, result unchanged.
- reset pulsed mid-SQR → busy=0 next cycle, no done. New start → correct result 0x0400 for the first vector.
- MONT_EXPO_CT_EN defined: y=0x0001 and y=0xFFFF have equal start-to-done latency; results are 2 and 2^65535 mod m, matching the golden model.
